// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolutional encoder.
//   conv_state_e    : encoder FSM states (S_DATA, S_TAIL)
//   GEN_K4_R2       : K=4 rate-1/2 generators {1011, 1111}
//   GEN_K7_R2       : K=7 rate-1/2 generators, 171 (out_sym[0]) / 133 (out_sym[1]) octal
//   tail_cnt_width  : width of the tail down-counter for a given K
package conv_pkg;

  typedef enum logic [0:0] {
    S_DATA = 1'b0,
    S_TAIL = 1'b1
  } conv_state_e;

  localparam logic [7:0]  GEN_K4_R2 = {4'b1011, 4'b1111};
  localparam logic [13:0] GEN_K7_R2 = {7'o133, 7'o171};

  // The counter only has to hold K-2, but $clog2(K) keeps K=2 at one bit.
  function automatic int tail_cnt_width(input int k);
    return (k < 2) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/conv_parity.sv
// conv_parity: combinational masked-XOR of the encoder window, one output
// per generator.
//   win_i [K-1:0] : window {b, sr}, bit K-1 is the newest bit
//   par_o [N-1:0] : par_o[j] = XOR(GEN[j*K +: K] & win_i)
module conv_parity #(
  parameter int K = 4,
  parameter int N = 2,
  parameter logic [N*K-1:0] GEN = '0
) (
  input  logic [K-1:0] win_i,
  output logic [N-1:0] par_o
);

  always_comb begin
    par_o = '0;
    for (int j = 0; j < N; j++) begin
      par_o[j] = ^(GEN[j*K +: K] & win_i);
    end
  end

endmodule

// File: rtl/conv_encode_tail.sv
// conv_encode_tail: rate-1/N feed-forward convolutional encoder with
// valid/ready on both sides and optional zero-tail frame termination.
//
// Build option: define CONV_TAIL_EN to append K-1 zero-input tail symbols
// after every in_last bit (trellis returns to the zero state). Without it the
// shift state runs continuously across frames and out_last follows in_last.
//
// Ports:
//   clk_sig    in   clock, rising edge
//   rst_n_sig  in   asynchronous active-low reset
//   clr_sig    in   synchronous clear (output register, shift state, FSM)
//   in_valid   in   in_bit valid
//   in_ready   out  encoder accepts in_bit this cycle
//   in_bit     in   information bit
//   in_last    in   last info bit of the frame
//   out_valid  out  out_sym valid
//   out_ready  in   downstream accepts out_sym
//   out_sym    out  [N-1:0] coded symbol, bit j from generator j
//   out_last   out  final symbol of the frame
//
// FSM states (CONV_TAIL_EN builds only):
//   state  | meaning
//   S_DATA | accepting info bits, one symbol per accepted bit
//   S_TAIL | input blocked, encoding zeros until tail_cnt reaches 0
module conv_encode_tail
  import conv_pkg::*;
#(
  parameter int K = 4,
  parameter int N = 2,
  parameter logic [N*K-1:0] GEN = GEN_K4_R2
) (
  input  logic         clk_sig,
  input  logic         rst_n_sig,
  input  logic         clr_sig,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sym,
  output logic         out_last
);

  logic [K-2:0] sr_q, sr_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_sym_q, out_sym_d;
  logic         out_last_q, out_last_d;

  logic         advance;
  logic         accept;
  logic         enc_bit;
  logic [K-1:0] win;
  logic [N-1:0] par;

  // Output register can take a new symbol when empty or being drained.
  assign advance = !out_valid_q || out_ready;
  assign win     = {enc_bit, sr_q};

  conv_parity #(
    .K   (K),
    .N   (N),
    .GEN (GEN)
  ) u_parity (
    .win_i (win),
    .par_o (par)
  );

`ifdef CONV_TAIL_EN
  localparam int TCW = tail_cnt_width(K);
  localparam logic [TCW-1:0] TAIL_INIT = TCW'(K - 2);

  conv_state_e    state_q, state_d;
  logic [TCW-1:0] tail_cnt_q, tail_cnt_d;

  // rst_n_sig gates in_ready so nothing looks acceptable while in reset.
  assign in_ready = rst_n_sig && (state_q == S_DATA) && advance && !clr_sig;
  assign enc_bit  = (state_q == S_DATA) ? in_bit : 1'b0;
`else
  assign in_ready = rst_n_sig && advance && !clr_sig;
  assign enc_bit  = in_bit;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    sr_d        = sr_q;
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    out_last_d  = out_last_q;
`ifdef CONV_TAIL_EN
    state_d     = state_q;
    tail_cnt_d  = tail_cnt_q;
`endif
    if (clr_sig) begin
      sr_d        = '0;
      out_valid_d = 1'b0;
      out_sym_d   = '0;
      out_last_d  = 1'b0;
`ifdef CONV_TAIL_EN
      state_d     = S_DATA;
      tail_cnt_d  = '0;
`endif
    end
`ifdef CONV_TAIL_EN
    else if (state_q == S_TAIL) begin
      if (advance) begin
        out_valid_d = 1'b1;
        out_sym_d   = par;
        out_last_d  = (tail_cnt_q == '0);
        sr_d        = win[K-1:1];
        if (tail_cnt_q == '0) begin
          state_d = S_DATA;
        end else begin
          tail_cnt_d = tail_cnt_q - TCW'(1);
        end
      end
    end
`endif
    else if (accept) begin
      out_valid_d = 1'b1;
      out_sym_d   = par;
      sr_d        = win[K-1:1];
`ifdef CONV_TAIL_EN
      out_last_d  = 1'b0;
      if (in_last) begin
        state_d    = S_TAIL;
        tail_cnt_d = TAIL_INIT;
      end
`else
      out_last_d  = in_last;
`endif
    end else if (advance) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sig or negedge rst_n_sig) begin
    if (!rst_n_sig) begin
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef CONV_TAIL_EN
  always_ff @(posedge clk_sig or negedge rst_n_sig) begin
    if (!rst_n_sig) begin
      state_q    <= S_DATA;
      tail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tail_cnt_q <= tail_cnt_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_encode_tail.sv
`timescale 1ns/1ps
module tb_conv_encode_tail;

  localparam int K = 4;
  localparam int N = 2;
  localparam logic [N*K-1:0] GEN = {4'b1011, 4'b1111};
`ifdef CONV_TAIL_EN
  localparam int TAILN = K - 1;
`else
  localparam int TAILN = 0;
`endif

  logic         clk_sig = 1'b0;
  logic         rst_n_sig;
  logic         clr_sig;
  logic         in_valid;
  logic         in_ready;
  logic         in_bit;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sym;
  logic         out_last;

  typedef struct {
    logic [N-1:0] sym;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];     // symbols the model says are still owed
  logic         hist_q[$];    // past info bits, most recent first (K-1 deep)
  logic [N-1:0] got_sym[$];
  logic         got_last[$];
  int           got_cyc[$];
  int           n_cmp = 0;
  int           n_mis = 0;
  int           cyc = 0;
  logic         rand_rdy = 1'b0;

  always #5 clk_sig = ~clk_sig;

  conv_encode_tail #(.K(K), .N(N), .GEN(GEN)) dut (
    .clk_sig   (clk_sig),
    .rst_n_sig (rst_n_sig),
    .clr_sig   (clr_sig),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .out_last  (out_last)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: out[j] = parity of generator taps over the last K info bits,
  // tap K-1 being the current bit and tap K-1-d the bit d steps ago.
  function automatic logic [N-1:0] model_sym(input logic b);
    logic [N-1:0] s;
    logic         bit_at;
    s = '0;
    for (int j = 0; j < N; j++) begin
      for (int d = 0; d < K; d++) begin
        bit_at = (d == 0) ? b : hist_q[d-1];
        if (GEN[j*K + K-1-d] && bit_at) s[j] = ~s[j];
      end
    end
    return s;
  endfunction

  task automatic model_push(input logic b, input logic last);
    exp_t e;
    e.sym  = model_sym(b);
    e.last = last;
    exp_q.push_back(e);
    hist_q.push_front(b);
    hist_q.delete(K-1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist_q.delete();
    for (int d = 0; d < K-1; d++) hist_q.push_back(1'b0);
  endtask

  task automatic model_accept(input logic b, input logic last);
    model_push(b, (TAILN == 0) ? last : 1'b0);
    if (last && TAILN > 0)
      for (int t = 0; t < TAILN; t++) model_push(1'b0, t == TAILN-1);
  endtask

  // Scoreboard: handshakes are sampled mid-cycle, where they equal the values
  // seen by the next rising edge.
  always @(negedge clk_sig) begin : p_mon
    exp_t e;
    cyc++;
    if (!rst_n_sig) begin
      model_reset();
    end else begin
      if (out_valid && out_ready) begin
        got_sym.push_back(out_sym);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_val("extra_sym", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("sb_sym", out_sym, e.sym);
          check_val("sb_last", out_last, e.last);
        end
      end
      if (clr_sig) model_reset();
      else if (in_valid && in_ready) model_accept(in_bit, in_last);
    end
  end

  task automatic send_bit(input logic b, input logic l, output int n);
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    do begin
      @(negedge clk_sig);
      acc = in_ready;
      @(posedge clk_sig);
      #1;
      n++;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end while (!acc && n < 200);
    if (!acc) check_val("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk_sig);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_syms(input int target);
    int k = 0;
    while (got_sym.size() < target && k < 200) begin
      @(posedge clk_sig);
      #1;
      k++;
    end
    if (got_sym.size() < target) check_val("wait_syms_timeout", got_sym.size(), target);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 300) begin
      @(posedge clk_sig);
      #1;
      k++;
    end
    check_val("drain_left", exp_q.size(), 0);
  endtask

  task automatic cmp_frame(input string tag, input int base,
                           input logic [N-1:0] es[$], input logic el[$]);
    for (int i = 0; i < es.size(); i++) begin
      if (base + i < got_sym.size()) begin
        check_val({tag, "_sym"}, got_sym[base+i], es[i]);
        check_val({tag, "_last"}, got_last[base+i], el[i]);
      end else begin
        check_val({tag, "_missing"}, 0, 1);
      end
    end
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : p_main
    int n;
    int base;
    int idx;
    logic [N-1:0] f1_sym[$];
    logic [N-1:0] f2_sym[$];
    logic         f1_last[$];
    logic         f2_last[$];

`ifdef CONV_TAIL_EN
    f1_sym  = '{2'b11, 2'b01, 2'b11, 2'b11};
    f1_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    f2_sym  = '{2'b00, 2'b00, 2'b00, 2'b00};
    f2_last = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
    f1_sym  = '{2'b11};
    f1_last = '{1'b1};
    f2_sym  = '{2'b01};
    f2_last = '{1'b1};
`endif

    model_reset();
    rst_n_sig = 1'b0;
    clr_sig   = 1'b0;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk_sig);
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_sym", out_sym, 0);
    check_val("rst_out_last", out_last, 0);
    in_valid  = 1'b0;
    rst_n_sig = 1'b1;
    @(posedge clk_sig);
    #1;
    check_val("idle_in_ready", in_ready, 1);

    // Impulse frame, then a "0 (last)" frame
    base = got_sym.size();
    send_bit(1'b1, 1'b1, n);
    wait_syms(base + 1 + TAILN);
    cmp_frame("impulse", base, f1_sym, f1_last);
    wait_drain();
    base = got_sym.size();
    send_bit(1'b0, 1'b1, n);
    wait_syms(base + 1 + TAILN);
    cmp_frame("frame2", base, f2_sym, f2_last);
    wait_drain();

    // 64 random bits at full rate, then the next frame's first bit
    base = got_sym.size();
    for (int i = 0; i < 64; i++) send_bit(1'($urandom_range(0, 1)), i == 63, n);
    send_bit(1'b1, 1'b1, n);
    check_val("tail_stall_cycles", n - 1, TAILN);
    wait_syms(base + 64 + TAILN + 1 + TAILN);
    idx = base;
    while (idx < got_sym.size() && !got_last[idx]) idx++;
    check_val("stream_len", idx - base + 1, 64 + TAILN);
    if (idx < got_sym.size())
      check_val("stream_rate", got_cyc[idx] - got_cyc[base], 64 + TAILN - 1);
    wait_drain();

    // Back-pressure mid-frame for 5 cycles
    base = got_sym.size();
    send_bit(1'b1, 1'b0, n);
    send_bit(1'b0, 1'b0, n);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    in_last   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sig);
      check_val("bp_valid", out_valid, 1);
      check_val("bp_in_ready", in_ready, 0);
      if (exp_q.size() > 0) begin
        check_val("bp_sym", out_sym, exp_q[0].sym);
        check_val("bp_last", out_last, exp_q[0].last);
      end else begin
        check_val("bp_model_empty", 0, 1);
      end
    end
    @(posedge clk_sig);
    #1;
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1, n);
    wait_drain();
    check_val("bp_count", got_sym.size() - base, 3 + TAILN);

    // Asynchronous reset part-way through a frame
    base = got_sym.size();
`ifdef CONV_TAIL_EN
    send_bit(1'b1, 1'b1, n);
    wait_syms(base + 2);
`else
    out_ready = 1'b0;
    send_bit(1'b1, 1'b0, n);
`endif
    check_val("pre_rst_valid", out_valid, 1);
    rst_n_sig = 1'b0;
    #1;
    check_val("arst_out_valid", out_valid, 0);
    check_val("arst_out_sym", out_sym, 0);
    check_val("arst_out_last", out_last, 0);
    check_val("arst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk_sig);
    @(posedge clk_sig);
    #1;
    rst_n_sig = 1'b1;
    out_ready = 1'b1;
    base = got_sym.size();
    send_bit(1'b1, 1'b1, n);
    wait_syms(base + 1 + TAILN);
    if (base < got_sym.size()) check_val("post_rst_sym", got_sym[base], 2'b11);
    wait_drain();

    // Clear while a symbol is stalled and a new bit is offered
    out_ready = 1'b0;
    send_bit(1'b1, 1'b0, n);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    in_last  = 1'b0;
    clr_sig  = 1'b1;
    @(negedge clk_sig);
    check_val("clr_pre_valid", out_valid, 1);
    check_val("clr_in_ready", in_ready, 0);
    @(posedge clk_sig);
    #1;
    clr_sig  = 1'b0;
    in_valid = 1'b0;
    check_val("clr_out_valid", out_valid, 0);
    out_ready = 1'b1;
    base = got_sym.size();
    send_bit(1'b1, 1'b1, n);
    wait_syms(base + 1 + TAILN);
    if (base < got_sym.size()) check_val("clr_sr_zero", got_sym[base], 2'b11);
    wait_drain();

    // Random frames, gaps and back-pressure against the model
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, n);
    end
    send_bit(1'b0, 1'b1, n);
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check_val("final_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
